// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Purpose  : Shared types and constants for the two-product vending machine
//             sequencer: state encoding, coin codes, datapath widths and
//             product indices.
//  Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Datapath widths
  localparam int CREDIT_W = 4;   // credit in Rs.5 units, ceiling 8
  localparam int STOCK_W  = 4;   // per-product stock, reload value 8
  localparam int TIMER_W  = 10;  // idle timer, terminal count 999

  // Coin acceptor codes; 2'b00 and 2'b11 carry no value
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  // Product indices (sel_id values and stock array slots)
  localparam int PROD_A = 0;
  localparam int PROD_B = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  // Value of a coin code in Rs.5 units (only meaningful for valid codes)
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] code);
    return (code == COIN_10) ? CREDIT_W'(2) : CREDIT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_timeout_timer
//  Purpose  : Idle-credit timer. Clears on request, counts while enabled and
//             holds at the terminal count TIMEOUT-1.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             clear         - synchronous clear (wins over enable)
//             enable        - count this cycle
//             expired       - enable is high and the count sits at TIMEOUT-1
//  Revision : 1.0 - initial release
// ============================================================================
module vend_timeout_timer
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] TERMINAL = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = enable && (count == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vend_sequencer
//  Purpose  : Two-product vending machine sequencer working in Rs.5 units.
//             Accumulates coin credit, handles select/cancel/timeout, drives
//             the dispense motor and change hopper through req/ack handshakes
//             and tracks per-product stock.
//  Ports    : clk, rst                 - clock, asynchronous active-high reset
//             coin_valid, coin_val     - coin event and code (01=Rs.5, 10=Rs.10)
//             sel_valid, sel_id        - product select event and product
//             cancel                   - refund request
//             restock                  - reload both stock counters (IDLE only)
//             dispense_done            - motor completion
//             hopper_ack               - one Rs.5 coin ejected
//             dispense_req, dispense_id- motor request and product
//             hopper_req               - change owed
//             coin_reject, sel_error   - one-cycle refusal pulses
//             credit                   - current credit in units
//             sold_out                 - bit i set when product i stock is 0
//             busy                     - in DISPENSE or CHANGE
//  Revision : 1.0 - initial release
// ============================================================================
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 4,
  parameter int MAX_CREDIT = 8,
  parameter int TIMEOUT    = 1000,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                sel_valid,
  input  logic                sel_id,
  input  logic                cancel,
  input  logic                restock,
  input  logic                dispense_done,
  input  logic                hopper_ack,
  output logic                dispense_req,
  output logic                dispense_id,
  output logic                hopper_req,
  output logic                coin_reject,
  output logic                sel_error,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          sold_out,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_A_U  = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_U  = CREDIT_W'(PRICE_B);
  localparam logic [CREDIT_W:0]   MAX_SUM    = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  STOCK_LOAD = STOCK_W'(STOCK_INIT);

  state_t                   state;
  logic [1:0][STOCK_W-1:0]  stock;

  logic                     coin_ok;
  logic [CREDIT_W-1:0]      coin_amt;
  logic [CREDIT_W:0]        credit_sum;
  logic [CREDIT_W-1:0]      price;
  logic                     coin_accept;
  logic                     sel_accept;
  logic                     timer_clear;
  logic                     timer_en;
  logic                     timer_expired;

  // Event decode. A pending cancel refuses any select or coin in the same
  // cycle, and a select refuses a coin, whatever state the machine is in.
  always_comb begin
    coin_ok     = coin_valid && ((coin_val == COIN_5) || (coin_val == COIN_10));
    coin_amt    = coin_units(coin_val);
    credit_sum  = {1'b0, credit} + {1'b0, coin_amt};
    price       = sel_id ? PRICE_B_U : PRICE_A_U;
    sel_accept  = sel_valid && !cancel && (state == ST_CREDIT) &&
                  (credit >= price) && (stock[sel_id] != '0);
    coin_accept = coin_ok && !cancel && !sel_valid &&
                  ((state == ST_IDLE) || (state == ST_CREDIT)) &&
                  (credit_sum <= MAX_SUM);
  end

  // The timer only runs in CREDIT; any accepted coin restarts it, and it is
  // held at zero everywhere else so CREDIT is always entered with a fresh count.
  assign timer_en    = (state == ST_CREDIT);
  assign timer_clear = coin_accept || (state != ST_CREDIT);

  vend_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      credit       <= '0;
      stock        <= {STOCK_LOAD, STOCK_LOAD};
      dispense_req <= 1'b0;
      dispense_id  <= 1'b0;
      hopper_req   <= 1'b0;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Any valid coin or select not taken this cycle is refused.
      coin_reject <= coin_ok && !coin_accept;
      sel_error   <= sel_valid && !sel_accept;

      case (state)
        ST_IDLE: begin
          if (restock) begin
            stock <= {STOCK_LOAD, STOCK_LOAD};
          end
          if (coin_accept) begin
            credit <= credit_sum[CREDIT_W-1:0];
            state  <= ST_CREDIT;
          end
        end

        ST_CREDIT: begin
          if (cancel) begin
            state      <= ST_CHANGE;
            hopper_req <= 1'b1;
            busy       <= 1'b1;
          end else if (sel_accept) begin
            credit        <= credit - price;
            stock[sel_id] <= stock[sel_id] - STOCK_W'(1);
            dispense_req  <= 1'b1;
            dispense_id   <= sel_id;
            state         <= ST_DISPENSE;
            busy          <= 1'b1;
          end else if (coin_accept) begin
            credit <= credit_sum[CREDIT_W-1:0];
          end else if (timer_expired) begin
            state      <= ST_CHANGE;
            hopper_req <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_DISPENSE: begin
          if (dispense_done) begin
            dispense_req <= 1'b0;
            if (credit != '0) begin
              state      <= ST_CHANGE;
              hopper_req <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        ST_CHANGE: begin
          if (hopper_ack) begin
            credit <= credit - CREDIT_W'(1);
            // The ack paying out the last unit ends the refund.
            if (credit == CREDIT_W'(1)) begin
              hopper_req <= 1'b0;
              state      <= ST_IDLE;
              busy       <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sold_out = {(stock[PROD_B] == '0), (stock[PROD_A] == '0)};

endmodule
`default_nettype wire
